// File: rtl/xprod_arbiter.sv
// Round-robin arbiter feeding one shared two-stage signed cross-product unit
// (Ax*By - Bx*Ay); results return on a single tagged response bus with backpressure.
module xprod_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_ax,
  input  logic [NREQ*W-1:0] req_ay,
  input  logic [NREQ*W-1:0] req_bx,
  input  logic [NREQ*W-1:0] req_by,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2:0]        rsp_id,
  output logic [2*W:0]      rsp_value,
  output logic [1:0]        rsp_sign,
  output logic              idle
);

  localparam int PW = 2 * W;
  localparam int RW = 2 * W + 1;
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  logic [2:0]            ptr;
  logic [2:0]            ptr_next;
  logic [2:0]            gidx;
  logic [3:0]            cand;
  logic [NREQ-1:0]       mask;
  logic [NREQ-1:0]       grant;
  logic                  found;
  logic                  adv;
  logic                  accept;

  logic signed [W-1:0]   sel_ax;
  logic signed [W-1:0]   sel_ay;
  logic signed [W-1:0]   sel_bx;
  logic signed [W-1:0]   sel_by;

  logic signed [PW-1:0]  p1;
  logic signed [PW-1:0]  p2;
  logic [2:0]            id1;
  logic                  v1;
  logic signed [RW-1:0]  diff;

  assign adv = !rsp_valid || rsp_ready;

  // Search starts at ptr and wraps; the first valid requester found wins.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    cand  = '0;
    mask  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + 4'(i);
      if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
      mask = ONE << cand;
      if (!found && (|(req_valid & mask))) begin
        found = 1'b1;
        grant = mask;
        gidx  = cand[2:0];
      end
    end
  end

  // Grants are suppressed while reset is held so nothing can handshake into a cleared pipe.
  assign req_ready = (found && adv && reset) ? grant : '0;
  assign accept    = |(req_ready & req_valid);
  assign ptr_next  = (gidx == 3'(NREQ - 1)) ? 3'd0 : gidx + 3'd1;

  always_comb begin
    sel_ax = '0;
    sel_ay = '0;
    sel_bx = '0;
    sel_by = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_ax = req_ax[i*W +: W];
        sel_ay = req_ay[i*W +: W];
        sel_bx = req_bx[i*W +: W];
        sel_by = req_by[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      p1  <= PW'(sel_ax) * PW'(sel_by);
      p2  <= PW'(sel_bx) * PW'(sel_ay);
      id1 <= gidx;
    end
  end

  assign diff = RW'(p1) - RW'(p2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1        <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_value <= '0;
      ptr       <= '0;
    end else if (adv) begin
      v1        <= accept;
      rsp_valid <= v1;
      rsp_id    <= id1;
      rsp_value <= diff;
      if (accept) ptr <= ptr_next;
    end
  end

  always_comb begin
    if (rsp_value[RW-1])  rsp_sign = 2'd1;
    else if (|rsp_value) rsp_sign = 2'd2;
    else                  rsp_sign = 2'd0;
  end

  assign idle = !v1 && !rsp_valid && !(|req_valid);

endmodule

// File: tb/tb_xprod_arbiter.sv
// Directed bench for xprod_arbiter: arithmetic, round-robin order, backpressure
// and asynchronous reset, with hand-computed expectations.
module tb_xprod_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 11;
  localparam int RW   = 2 * W + 1;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_ax;
  logic [NREQ*W-1:0] req_ay;
  logic [NREQ*W-1:0] req_bx;
  logic [NREQ*W-1:0] req_by;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [2:0]        rsp_id;
  logic [RW-1:0]     rsp_value;
  logic [1:0]        rsp_sign;
  logic              idle;

  int checks = 0;
  int errors = 0;

  xprod_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ax    (req_ax),
    .req_ay    (req_ay),
    .req_bx    (req_bx),
    .req_by    (req_by),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_value (rsp_value),
    .rsp_sign  (rsp_sign),
    .idle      (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] val(input int x);
    logic [31:0] r;
    r = '0;
    r[RW-1:0] = x[RW-1:0];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int ax, input int ay, input int bx, input int by);
    req_ax[i*W +: W] = ax[W-1:0];
    req_ay[i*W +: W] = ay[W-1:0];
    req_bx[i*W +: W] = bx[W-1:0];
    req_by[i*W +: W] = by[W-1:0];
  endtask

  task automatic chk_rsp(input string tag, input int id, input int value, input int sign);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_id"},    32'(rsp_id),    32'(id));
    chk({tag, "_value"}, val(32'(rsp_value)), val(value));
    chk({tag, "_sign"},  32'(rsp_sign),  32'(sign));
  endtask

  initial begin
    reset     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_ax    = '0;
    req_ay    = '0;
    req_bx    = '0;
    req_by    = '0;
    #2;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id",    32'(rsp_id),    32'd0);
    chk("rst_rsp_value", 32'(rsp_value), 32'd0);
    chk("rst_rsp_sign",  32'(rsp_sign),  32'd0);
    chk("rst_idle",      32'(idle),      32'd1);
    req_valid = 4'b1111;
    #1;
    chk("rst_ready_forced", 32'(req_ready), 32'd0);
    chk("rst_idle_busy",    32'(idle),      32'd0);
    req_valid = '0;
    tick();
    tick();
    reset = 1'b1;
    tick();

    // single positive: 3*2 - 1*1 = 5
    set_req(0, 3, 1, 1, 2);
    req_valid = 4'b0001;
    #1;
    chk("pos_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    #1;
    chk("pos_lat1_valid", 32'(rsp_valid), 32'd0);
    chk("pos_lat1_idle",  32'(idle),      32'd0);
    tick();
    chk_rsp("pos", 0, 5, 2);
    tick();
    chk("pos_once", 32'(rsp_valid), 32'd0);
    chk("pos_idle", 32'(idle),      32'd1);

    // negative then zero from req 2, back-to-back (ptr is 1)
    set_req(2, 1, 2, 3, 1);
    req_valid = 4'b0100;
    #1;
    chk("neg_ready", 32'(req_ready), 32'b0100);
    tick();
    set_req(2, 2, 4, 1, 2);
    #1;
    chk("zero_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    chk_rsp("neg", 2, -5, 1);
    tick();
    chk_rsp("zero", 2, 0, 0);
    tick();

    // extremes from req 3 (ptr is 3, then wraps to 0)
    set_req(3, -1024, 1023, 1023, -1024);
    req_valid = 4'b1000;
    #1;
    chk("ext1_ready", 32'(req_ready), 32'b1000);
    tick();
    set_req(3, -1024, -1024, 1023, 1023);
    #1;
    chk("ext2_ready", 32'(req_ready), 32'b1000);
    tick();
    set_req(3, -1024, -1024, -1024, 1023);
    #1;
    chk("ext3_ready", 32'(req_ready), 32'b1000);
    chk_rsp("ext1", 3, 2047, 2);
    tick();
    req_valid = '0;
    chk_rsp("ext2", 3, 0, 0);
    tick();
    chk_rsp("ext3", 3, -2096128, 1);
    tick();

    // round robin: requester i yields i+1; ptr is 0
    for (int i = 0; i < NREQ; i++) set_req(i, i + 1, 0, 0, 1);
    req_valid = 4'b1111;
    #1;
    for (int n = 0; n < 8; n++) begin
      chk($sformatf("rr_ready%0d", n), 32'(req_ready), 32'(1 << (n % 4)));
      if (n >= 2) chk_rsp($sformatf("rr%0d", n), (n - 2) % 4, ((n - 2) % 4) + 1, 2);
      tick();
    end
    req_valid = '0;
    chk_rsp("rr8", 2, 3, 2);
    tick();
    chk_rsp("rr9", 3, 4, 2);
    tick();
    chk("rr_drain", 32'(rsp_valid), 32'd0);

    // backpressure: req 1 issues n -> (n+1)*3 - n = 2n+3; ptr is 0
    set_req(1, 1, 0, 1, 3);
    req_valid = 4'b0010;
    #1;
    chk("bp_ready0", 32'(req_ready), 32'b0010);
    tick();
    set_req(1, 2, 1, 1, 3);
    #1;
    chk("bp_ready1", 32'(req_ready), 32'b0010);
    tick();
    set_req(1, 3, 2, 1, 3);
    rsp_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      chk($sformatf("bp_hold_ready%0d", n), 32'(req_ready), 32'd0);
      chk_rsp($sformatf("bp_hold%0d", n), 1, 3, 2);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_resume_ready", 32'(req_ready), 32'b0010);
    chk_rsp("bp_a0", 1, 3, 2);
    tick();
    set_req(1, 4, 3, 1, 3);
    #1;
    chk("bp_ready3", 32'(req_ready), 32'b0010);
    chk_rsp("bp_a1", 1, 5, 2);
    tick();
    req_valid = '0;
    chk_rsp("bp_a2", 1, 7, 2);
    tick();
    chk_rsp("bp_a3", 1, 9, 2);
    tick();
    chk("bp_drain", 32'(rsp_valid), 32'd0);
    chk("bp_idle",  32'(idle),      32'd1);

    // reset mid-flight: two accepts from req 2 (ptr 2 -> 3), then reset clears ptr
    set_req(2, 5, 0, 0, 1);
    req_valid = 4'b0100;
    #1;
    chk("mid_ready0", 32'(req_ready), 32'b0100);
    tick();
    set_req(2, 6, 0, 0, 1);
    tick();
    req_valid = 4'b1010;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    tick();
    reset = 1'b1;
    set_req(1, 7, 1, 2, 2);
    set_req(3, 9, 0, 0, 1);
    #1;
    chk("mid_first_grant", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    #1;
    chk("mid_no_stale", 32'(rsp_valid), 32'd0);
    tick();
    chk_rsp("mid_new", 1, 12, 2);
    tick();
    chk("mid_end_valid", 32'(rsp_valid), 32'd0);
    chk("mid_end_idle",  32'(idle),      32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xprod_arbiter.md
# xprod_arbiter

Round-robin arbiter and 2-stage pipelined sequencer for one shared signed cross-product unit, computing Ax·By − Bx·Ay. The geofence engines (point sort, edge-side determination, future parallel query channels) issue operand sets here instead of instantiating their own multipliers. Each result is returned on a single shared response bus, tagged with the requester ID, with full backpressure.

## Interface
- NREQ, 4, number of requesters; legal range 2..8
- W, 11, signed operand width (10-bit coordinate differences plus sign)
- clk  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-low; clock clk
- req_valid  in  NREQ  requester i has an operand set pending
- req_ready  out  NREQ  one-hot grant; transfer happens when req_valid[i] & req_ready[i]
- req_ax, req_ay, req_bx, req_by  in  NREQ*W each  packed signed operands; requester i uses slice [i*W +: W]
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts the result
- rsp_id  out  3  index of the requester that owns the result
- rsp_value  out  2W+1  signed Ax·By − Bx·Ay
- rsp_sign  out  2  2 = positive, 1 = negative, 0 = zero
- idle  out  1  no transaction in flight and no req_valid asserted

## Operation
- adv = !rsp_valid | rsp_ready. When adv = 0 the whole pipeline holds and all req_ready bits are 0.
- Arbitration is combinational over req_valid, searching from priority pointer ptr upward with wrap. At most one req_ready bit is high, and only when adv = 1.
- ptr resets to 0. After an accepted transfer from requester k, ptr ← (k+1) mod NREQ. With no transfer, ptr holds.
- Stage 1, on accept with adv: register p1 = ax·by and p2 = bx·ay (each 2W signed, sign-extended), set id1 and v1. If adv = 1 with no accept, v1 ← 0.
- Stage 2, on adv: rsp_value ← p1 − p2 at 2W+1 bits, which never overflows. rsp_sign is derived from rsp_value. rsp_id ← id1, rsp_valid ← v1.
- Requester indices ≥ NREQ never appear on rsp_id.
- Throughput is one transaction per cycle when rsp_ready stays high.
- A requester may hold req_valid across multiple grants. Each grant consumes exactly one operand set, and the requester must update its operands on the cycle after the handshake.
- idle = !v1 & !rsp_valid & !(|req_valid).

## Timing
- Latency: a handshake at edge t produces rsp_valid at edge t+2 when rsp_ready is high throughout. Each cycle rsp_ready is low at a held result adds one cycle.
- While rsp_valid & !rsp_ready, rsp_value, rsp_sign and rsp_id hold stable. Stage-1 contents are also held, so no data is lost or duplicated.
- If rsp_ready rises in the same cycle as a new request, the arbiter grants in that cycle (adv = 1).
- Reset values: rsp_valid 0, rsp_id 0, rsp_value 0, rsp_sign 0, req_ready 0 (forced while reset is low), idle 1 when req_valid = 0, ptr 0, v1 0.
- Reset asserted mid-operation clears v1, rsp_valid and ptr immediately and asynchronously, discarding in-flight results. After release, the first grant goes to the lowest-indexed valid requester.
- Operand registers (p1, p2, id1) are not reset. Their contents are don't-care while the matching valid bit is 0.

## Test plan
- Single positive: req 0 with ax=3, ay=1, bx=1, by=2 and rsp_ready=1 -> at t+2: rsp_valid=1, rsp_id=0, rsp_value=5, rsp_sign=2, for one cycle only.
- Negative and zero: req 2 with (1,2,3,1) -> value −5, sign 1. Next cycle (2,4,1,2) -> value 0, sign 0. Results arrive back-to-back.
- Extremes: ax=−1024, by=−1024, bx=1023, ay=1023 -> rsp_value=2047, sign 2. Also ax=−1024, by=1023, bx=1023, ay=−1024 -> value 0. Checks width and sign extension.
- Round robin: all four req_valid held high for 8 cycles -> grants 0,1,2,3,0,1,2,3 back-to-back; rsp_id shows the same sequence from t+2; ptr wraps correctly.
- Backpressure: stream from req 1, with rsp_ready low for 3 cycles while rsp_valid is high -> rsp fields stable, req_ready=0 for those cycles, and every issued operand set returns exactly once, in order.
- Reset mid-flight: reset low one cycle after two accepts -> rsp_valid=0 immediately and no stale result afterwards. After release with req 3 and req 1 valid, the first grant goes to req 1.
